// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory, with starvation bound and host lock mode.
// Optional build macro DMEM_ARB_STATS_EN adds stall / host-grant statistics counters.
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd_en,
    input  logic          cpu_wr_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          cpu_halt,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   stat_stall_cnt,
    output logic [15:0]   stat_host_cnt,
`endif
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);

    typedef enum logic {RUN, LOCK} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       cpu_req;
    logic       cpu_gnt;

    assign cpu_req = cpu_rd_en | cpu_wr_en;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        host_gnt  = 1'b0;
        cpu_gnt   = 1'b0;
        cpu_stall = 1'b0;
        cpu_halt  = 1'b0;
        case (state)
            RUN: begin
                if (host_lock) state_nxt = LOCK;
                // Host wins when the core is idle or the host has waited out its limit.
                if (host_req && (!cpu_req || wait_cnt >= LIMIT)) host_gnt = 1'b1;
                else if (cpu_req)                                 cpu_gnt  = 1'b1;
                cpu_stall = cpu_req & ~cpu_gnt;
            end
            LOCK: begin
                if (!host_lock) state_nxt = RUN;
                host_gnt  = host_req;
                cpu_stall = cpu_req;
                cpu_halt  = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                       wait_cnt <= '0;
        else if (!host_req || host_gnt)  wait_cnt <= '0;
        else if (wait_cnt < LIMIT)       wait_cnt <= wait_cnt + 4'd1;
    end

    always_comb begin
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        mem_dat_in = '0;
        if (host_gnt) begin
            mem_wr_en  = host_we;
            mem_rd_en  = ~host_we;
            mem_addr   = host_addr;
            mem_dat_in = host_wdata;
        end else if (cpu_gnt) begin
            mem_wr_en  = cpu_wr_en;
            mem_rd_en  = cpu_rd_en;
            mem_addr   = cpu_addr;
            mem_dat_in = cpu_wdata;
        end
    end

    assign cpu_rdata = (cpu_gnt && cpu_rd_en) ? mem_dat_out : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= host_gnt & ~host_we;
            if (host_gnt && !host_we) host_rdata <= mem_dat_out;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall_cnt <= '0;
            stat_host_cnt  <= '0;
        end else begin
            if (cpu_stall && stat_stall_cnt != 16'hFFFF) stat_stall_cnt <= stat_stall_cnt + 16'd1;
            if (host_gnt && stat_host_cnt != 16'hFFFF)   stat_host_cnt  <= stat_host_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table for the documented scenarios,
// then constrained-random traffic against a rule-level reference model.
module tb_dmem_arbiter;

    localparam int STARVE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_rd_en, cpu_wr_en;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_stall, cpu_halt;
    logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       mem_wr_en, mem_rd_en;
    logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_stall_cnt, stat_host_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cpu_halt(cpu_halt), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_lock(host_lock),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_stall_cnt(stat_stall_cnt), .stat_host_cnt(stat_host_cnt),
`endif
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
    );

    // dat_mem stand-in: combinational read, clocked write
    logic [7:0] mem [256];
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

    typedef struct {
        logic rd, wr; logic [7:0] ca, cw;
        logic hr, hw; logic [7:0] ha, hd;
        logic lk, rst;
        logic gnt, stall, halt, rval; logic [7:0] rdat, crd;
        logic mwr, mrd; logic [7:0] maddr;
    } vec_t;

    function automatic vec_t mk(int rd, int wr, int ca, int cw, int hr, int hw, int ha, int hd,
                                int lk, int rst, int gnt, int stall, int halt, int rval,
                                int rdat, int crd, int mwr, int mrd, int maddr);
        vec_t v;
        v.rd = 1'(rd); v.wr = 1'(wr); v.ca = 8'(ca); v.cw = 8'(cw);
        v.hr = 1'(hr); v.hw = 1'(hw); v.ha = 8'(ha); v.hd = 8'(hd);
        v.lk = 1'(lk); v.rst = 1'(rst);
        v.gnt = 1'(gnt); v.stall = 1'(stall); v.halt = 1'(halt); v.rval = 1'(rval);
        v.rdat = 8'(rdat); v.crd = 8'(crd);
        v.mwr = 1'(mwr); v.mrd = 1'(mrd); v.maddr = 8'(maddr);
        return v;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: lock flag, count of consecutive refused host cycles, shadow memory
    logic       m_lock;
    int         m_refused;
    logic       m_rvalid;
    logic [7:0] m_rdata;
    logic [7:0] ref_mem [256];
    int         m_sc, m_hc;
    logic       e_hwin, e_cwin, e_stall, e_mwr, e_mrd;
    logic [7:0] e_maddr, e_mdin, e_crd;

    task automatic model_eval(input vec_t v);
        logic creq;
        creq    = v.rd | v.wr;
        e_hwin  = v.hr && (m_lock || !creq || m_refused >= STARVE);
        e_cwin  = !m_lock && creq && !e_hwin;
        e_stall = creq && !e_cwin;
        e_mwr   = e_hwin ? v.hw  : (e_cwin && v.wr);
        e_mrd   = e_hwin ? !v.hw : (e_cwin && v.rd);
        e_maddr = e_hwin ? v.ha : (e_cwin ? v.ca : 8'h00);
        e_mdin  = e_hwin ? v.hd : (e_cwin ? v.cw : 8'h00);
        e_crd   = (e_cwin && v.rd) ? ref_mem[v.ca] : 8'h00;
    endtask

    task automatic model_clock(input vec_t v);
        if (e_hwin && v.hw) ref_mem[v.ha] = v.hd;
        if (e_cwin && v.wr) ref_mem[v.ca] = v.cw;
        if (v.rst) begin
            m_lock = 0; m_refused = 0; m_rvalid = 0; m_rdata = 0; m_sc = 0; m_hc = 0;
        end else begin
            if (e_hwin && !v.hw) m_rdata = mem[v.ha];
            m_rvalid  = e_hwin && !v.hw;
            m_refused = (v.hr && !e_hwin) ? ((m_refused + 1 > STARVE) ? STARVE : m_refused + 1) : 0;
            m_lock    = v.lk;
            if (e_stall && m_sc < 65535) m_sc++;
            if (e_hwin && m_hc < 65535)  m_hc++;
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_rd_en = v.rd; cpu_wr_en = v.wr; cpu_addr = v.ca; cpu_wdata = v.cw;
        host_req = v.hr; host_we = v.hw; host_addr = v.ha; host_wdata = v.hd;
        host_lock = v.lk; reset = v.rst;
    endtask

    task automatic cycle(input vec_t v, input bit tchk, input bit mchk, input int idx);
        string s;
        drive(v);
        @(negedge clk);
        model_eval(v);
        if (tchk) begin
            s = $sformatf("vec%0d", idx);
            chk({s, ".host_gnt"},    32'(host_gnt),    32'(v.gnt));
            chk({s, ".cpu_stall"},   32'(cpu_stall),   32'(v.stall));
            chk({s, ".cpu_halt"},    32'(cpu_halt),    32'(v.halt));
            chk({s, ".host_rvalid"}, 32'(host_rvalid), 32'(v.rval));
            chk({s, ".host_rdata"},  32'(host_rdata),  32'(v.rdat));
            chk({s, ".cpu_rdata"},   32'(cpu_rdata),   32'(v.crd));
            chk({s, ".mem_wr_en"},   32'(mem_wr_en),   32'(v.mwr));
            chk({s, ".mem_rd_en"},   32'(mem_rd_en),   32'(v.mrd));
            chk({s, ".mem_addr"},    32'(mem_addr),    32'(v.maddr));
        end
        if (mchk) begin
            s = $sformatf("rnd%0d", idx);
            chk({s, ".host_gnt"},    32'(host_gnt),    32'(e_hwin));
            chk({s, ".cpu_stall"},   32'(cpu_stall),   32'(e_stall));
            chk({s, ".cpu_halt"},    32'(cpu_halt),    32'(m_lock));
            chk({s, ".host_rvalid"}, 32'(host_rvalid), 32'(m_rvalid));
            chk({s, ".host_rdata"},  32'(host_rdata),  32'(m_rdata));
            chk({s, ".cpu_rdata"},   32'(cpu_rdata),   32'(e_crd));
            chk({s, ".mem_wr_en"},   32'(mem_wr_en),   32'(e_mwr));
            chk({s, ".mem_rd_en"},   32'(mem_rd_en),   32'(e_mrd));
            chk({s, ".mem_addr"},    32'(mem_addr),    32'(e_maddr));
            chk({s, ".mem_dat_in"},  32'(mem_dat_in),  32'(e_mdin));
`ifdef DMEM_ARB_STATS_EN
            chk({s, ".stat_stall"},  32'(stat_stall_cnt), 32'(m_sc));
            chk({s, ".stat_host"},   32'(stat_host_cnt),  32'(m_hc));
`endif
        end
        @(posedge clk);
        model_clock(v);
        #1;
    endtask

    vec_t tbl [22];
    vec_t cur, idle, rst_v;

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
        m_lock = 0; m_refused = 0; m_rvalid = 0; m_rdata = 0; m_sc = 0; m_hc = 0;

        //           rd wr ca    cw    hr hw ha    hd    lk rst gnt st hlt rv rdat  crd   mwr mrd maddr
        tbl[0]  = mk(0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0,  0,  0, 0,  0, 'h00, 'h00, 0, 0, 'h00);
        tbl[1]  = mk(1, 0, 'h10, 'h00, 0, 0, 'h00, 'h00, 0, 0,  0,  0, 0,  0, 'h00, 'h5A, 0, 1, 'h10);
        tbl[2]  = mk(0, 0, 'h00, 'h00, 1, 1, 'h20, 'h33, 0, 0,  1,  0, 0,  0, 'h00, 'h00, 1, 0, 'h20);
        tbl[3]  = mk(0, 0, 'h00, 'h00, 1, 0, 'h20, 'h00, 0, 0,  1,  0, 0,  0, 'h00, 'h00, 0, 1, 'h20);
        tbl[4]  = mk(0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0,  0,  0, 0,  1, 'h33, 'h00, 0, 0, 'h00);
        for (int i = 5; i < 8; i++)
        tbl[i]  = mk(1, 0, 'h10, 'h00, 1, 0, 'h20, 'h00, 0, 0,  0,  0, 0,  0, 'h33, 'h5A, 0, 1, 'h10);
        tbl[8]  = mk(1, 0, 'h10, 'h00, 1, 0, 'h20, 'h00, 0, 0,  1,  1, 0,  0, 'h33, 'h00, 0, 1, 'h20);
        tbl[9]  = mk(0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0,  0,  0, 0,  1, 'h33, 'h00, 0, 0, 'h00);
        tbl[10] = mk(1, 0, 'h10, 'h00, 1, 0, 'h20, 'h00, 0, 0,  0,  0, 0,  0, 'h33, 'h5A, 0, 1, 'h10);
        tbl[11] = mk(0, 1, 'h30, 'h77, 0, 0, 'h00, 'h00, 1, 0,  0,  0, 0,  0, 'h33, 'h00, 1, 0, 'h30);
        for (int i = 0; i < 4; i++)
        tbl[12+i] = mk(0, 1, 'h30, 'h88, 1, 1, 'h40+i, 1+i, 1, 0, 1, 1, 1,  0, 'h33, 'h00, 1, 0, 'h40+i);
        tbl[16] = mk(0, 1, 'h30, 'h88, 0, 0, 'h00, 'h00, 0, 0,  0,  1, 1,  0, 'h33, 'h00, 0, 0, 'h00);
        tbl[17] = mk(0, 1, 'h30, 'h88, 0, 0, 'h00, 'h00, 0, 0,  0,  0, 0,  0, 'h33, 'h00, 1, 0, 'h30);
        tbl[18] = mk(0, 0, 'h00, 'h00, 1, 0, 'h41, 'h00, 0, 1,  1,  0, 0,  0, 'h33, 'h00, 0, 1, 'h41);
        tbl[19] = mk(0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0,  0,  0, 0,  0, 'h00, 'h00, 0, 0, 'h00);
        tbl[20] = mk(1, 0, 'h30, 'h00, 1, 0, 'h41, 'h00, 0, 0,  0,  0, 0,  0, 'h00, 'h88, 0, 1, 'h30);
        tbl[21] = mk(0, 0, 'h00, 'h00, 0, 0, 'h00, 'h00, 0, 0,  0,  0, 0,  0, 'h00, 'h00, 0, 0, 'h00);

        idle  = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        rst_v = idle; rst_v.rst = 1'b1;
        cycle(rst_v, 0, 0, 0);
        cycle(rst_v, 0, 0, 0);

        for (int i = 0; i < 22; i++) cycle(tbl[i], 1, 0, i);

        // The final memory value after the lock sequence and forced-write scenarios
        chk("mem30_final", 32'(mem[8'h30]), 32'h88);
        chk("mem43_lockwr", 32'(mem[8'h43]), 32'h04);

        // Random traffic honouring the hold-until-served protocol on both sides
        cur = idle;
        for (int n = 0; n < 600; n++) begin
            if (!(cur.hr && !e_hwin) || cur.rst) begin
                cur.hr = ($urandom_range(0, 2) != 0);
                cur.hw = 1'($urandom);
                cur.ha = 8'($urandom_range(0, 15));
                cur.hd = 8'($urandom);
            end
            if (!e_stall || cur.rst) begin
                case ($urandom_range(0, 2))
                    0: begin cur.rd = 0; cur.wr = 0; end
                    1: begin cur.rd = 1; cur.wr = 0; end
                    default: begin cur.rd = 0; cur.wr = 1; end
                endcase
                cur.ca = 8'($urandom_range(0, 15));
                cur.cw = 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) cur.lk = ~cur.lk;
            cur.rst = ($urandom_range(0, 63) == 0);
            cycle(cur, 0, 1, n);
        end

        // Full memory readback against the shadow copy
        for (int a = 0; a < 16; a++)
            chk($sformatf("mem%0d", a), 32'(mem[a]), 32'(ref_mem[a]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter that shares the data memory between the processor core and an external host port, used for preload, readback and debug. It sits between the core's load/store path and `dat_mem`. It grants one access per cycle, stalls the core when the host wins, and bounds host starvation with a wait counter. A lock mode lets the host halt the core and own the memory outright.

## Interface
- `AW`, default 8: memory address width.
- `DW`, default 8: data width.
- `STARVE_LIMIT`, default 3: host wait cycles, with the core holding memory, before the host is forced a grant; legal range 1..15.
- `clk  in  1`: single clock, all state updates on rising edge.
- `reset  in  1`: synchronous, active-high.
- `cpu_rd_en  in  1`: core load request.
- `cpu_wr_en  in  1`: core store request (never asserted together with `cpu_rd_en`).
- `cpu_addr  in  AW`: core address.
- `cpu_wdata  in  DW`: core store data.
- `cpu_rdata  out  DW`: load data, combinational, valid in the granted cycle.
- `cpu_stall  out  1`: core request not served this cycle; the core must hold PC and request.
- `cpu_halt  out  1`: lock mode active; the core freezes entirely.
- `host_req  in  1`: host access request; held with address/data until granted.
- `host_we  in  1`: 1 = write, 0 = read.
- `host_addr  in  AW`: host address.
- `host_wdata  in  DW`: host write data.
- `host_lock  in  1`: request exclusive ownership.
- `host_gnt  out  1`: host access performed this cycle.
- `host_rvalid  out  1`: registered pulse, one cycle after a granted host read.
- `host_rdata  out  DW`: registered read data, held until the next host read.
- `mem_wr_en  out  1`: to `dat_mem` write enable.
- `mem_rd_en  out  1`: to `dat_mem` read enable.
- `mem_addr  out  AW`: to `dat_mem` address.
- `mem_dat_in  out  DW`: to `dat_mem` write data.
- `mem_dat_out  in  DW`: from `dat_mem`; combinational read.

## Operation
- The FSM has two states.
  - `RUN` is the reset state. It moves to `LOCK` when `host_lock` = 1 is sampled.
  - `LOCK` returns to `RUN` when `host_lock` = 0 is sampled.
- `cpu_halt` is 1 exactly when the state is `LOCK`.
- `cpu_req` = `cpu_rd_en` | `cpu_wr_en`.
- Grant rules in `RUN`:
  - Only `cpu_req` active: the core is granted.
  - Only `host_req` active: the host is granted.
  - Both active and `wait_cnt` < `STARVE_LIMIT`: the core is granted and `host_gnt` = 0.
  - Both active and `wait_cnt` == `STARVE_LIMIT`: the host is granted and `cpu_stall` = 1.
- Grant rules in `LOCK`:
  - The host is granted whenever `host_req` = 1.
  - Core requests are ignored and `cpu_stall` = `cpu_req`.
- `wait_cnt` (4 bits):
  - Increments while `host_req` = 1 and `host_gnt` = 0.
  - Saturates at `STARVE_LIMIT`.
  - Clears on any host grant, or when `host_req` = 0.
- Memory port muxing:
  - The winner drives `mem_addr`, `mem_dat_in` and exactly one of `mem_wr_en`/`mem_rd_en`.
  - With no grant, both enables are 0 and the address/data outputs are 0.
- `cpu_rdata` = `mem_dat_out` when the core is granted a read, else 0.
- On a granted host read, `host_rdata` <= `mem_dat_out` and `host_rvalid` <= 1 on the next edge. Otherwise `host_rvalid` <= 0.

## Timing
- Reset values: state `RUN`, `wait_cnt` 0, `host_rvalid` 0, `host_rdata` 0, and any stats counters 0.
- With all inputs idle:
  - `cpu_stall`, `cpu_halt`, `host_gnt`, `mem_wr_en` and `mem_rd_en` are 0.
  - `cpu_rdata`, `mem_addr` and `mem_dat_in` are 0.
- Latency:
  - Core access: 0 cycles (combinational, same as direct `dat_mem`).
  - Host grant: combinational in the serving cycle.
  - Host read data: +1 cycle.
- Lock entry/exit takes effect the cycle after `host_lock` changes.
  - In the cycle `host_lock` first rises, `RUN` rules still apply.
- Reset mid-operation:
  - An in-flight `host_rvalid` is suppressed.
  - The FSM returns to `RUN`; host requests must be re-presented.
- Simultaneous core write and forced host write to the same address: only the host write occurs that cycle. The stalled core write repeats next cycle and is the final value.
- Worst-case host wait in `RUN` is `STARVE_LIMIT` cycles. The host never waits in `LOCK`.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - Adds outputs `stat_stall_cnt` (16 bits), which counts cycles with `cpu_stall` = 1.
  - Adds `stat_host_cnt` (16 bits), which counts host grants.
  - Both saturate at 0xFFFF and clear on reset.
- `DMEM_ARB_STATS_EN` undefined: those ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Reset, then idle: all outputs 0. Core read of addr 0x10, memory holding 0x5A -> `cpu_rdata` = 0x5A the same cycle, `cpu_stall` = 0.
- Host write 0x33 to 0x20 with the core idle -> `host_gnt` = 1 that cycle, `mem_wr_en` = 1, `mem_addr` = 0x20. A following host read of 0x20 -> `host_rvalid` = 1 next cycle with `host_rdata` = 0x33.
- Core requesting every cycle and host requesting continuously, `STARVE_LIMIT` = 3 -> `host_gnt` = 0 for 3 cycles, then `host_gnt` = 1 with `cpu_stall` = 1 on the 4th; `wait_cnt` back to 0.
- Assert `host_lock`, then run 4 host writes back-to-back while the core requests -> `cpu_halt` = 1 from the cycle after lock, 4 consecutive `host_gnt`, `cpu_stall` = 1 throughout. Drop lock -> core granted the cycle after.
- Assert reset the cycle after a host read grant -> `host_rvalid` stays 0, state `RUN`, `wait_cnt` 0.
- With `DMEM_ARB_STATS_EN`: rerun the starvation scenario -> `stat_stall_cnt` = 1, `stat_host_cnt` = 1.
